// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: mode encodings and uaddr field layout.
// The microcode assembler and the store rely on the same field positions.
package microcode_sequencer_pkg;

    localparam int unsigned UPC_W   = 7;
    localparam int unsigned IR_W    = 9;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned IBUS_W  = 16;
    localparam int unsigned UADDR_W = MODE_W + IR_W + 1 + UPC_W;

    // Bit positions (LSB) of each uaddr field.
    localparam int unsigned UA_UPC  = 0;
    localparam int unsigned UA_COND = UA_UPC + UPC_W;
    localparam int unsigned UA_IR   = UA_COND + 1;
    localparam int unsigned UA_MODE = UA_IR + IR_W;

    typedef enum logic [MODE_W-1:0] {
        ModeReset = 2'b00,
        ModeFetch = 2'b01,
        ModeExec  = 2'b10,
        ModeIrq   = 2'b11
    } mode_e;

    function automatic logic [UADDR_W-1:0] pack_uaddr(
        input mode_e            mode,
        input logic [IR_W-1:0]  ir,
        input logic             cond,
        input logic [UPC_W-1:0] upc
    );
        return {mode, ir, cond, upc};
    endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Control/status bundle between the instruction datapath, the decoded microword and
// the sequencer. The sequencer takes the slave side.
interface microcode_sequencer_if;
    import microcode_sequencer_pkg::*;

    logic                nhalt;
    logic                nwaiting;
    logic [IBUS_W-1:0]   ibus;
    logic                ir_ld;
    logic                uend;
    logic                cond_in;
    logic                irq_pend;
    logic                irq_en;
    logic [UADDR_W-1:0]  uaddr;
    mode_e               mode;
    logic                uerr;

    modport master (
        output nhalt,
        output nwaiting,
        output ibus,
        output ir_ld,
        output uend,
        output cond_in,
        output irq_pend,
        output irq_en,
        input  uaddr,
        input  mode,
        input  uerr
    );

    modport slave (
        input  nhalt,
        input  nwaiting,
        input  ibus,
        input  ir_ld,
        input  uend,
        input  cond_in,
        input  irq_pend,
        input  irq_en,
        output uaddr,
        output mode,
        output uerr
    );

endinterface

// File: rtl/microcode_sequencer_modefsm.sv
// Major-state register of the sequencer: RESET -> FETCH -> EXEC -> (IRQ ->) FETCH.
// Advances only on the end edge of a microcode step.
module microcode_sequencer_modefsm
    import microcode_sequencer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  advance,
    input  logic  irq_pend,
    input  logic  irq_en,
    output mode_e mode,
    output mode_e mode_next
);

    mode_e mode_q;
    mode_e mode_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= ModeReset;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (advance) begin
            unique case (mode_q)
                ModeReset: mode_d = ModeFetch;
                ModeFetch: mode_d = ModeExec;
                // Interrupts are only taken once the current instruction has finished.
                ModeExec:  mode_d = (irq_pend && irq_en) ? ModeIrq : ModeFetch;
                ModeIrq:   mode_d = ModeFetch;
                default:   mode_d = ModeReset;
            endcase
        end
    end

    assign mode      = mode_q;
    assign mode_next = mode_d;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode address sequencer: uPC, latched opcode and condition bit, concatenated with the
// major mode into the 19-bit microcode store address.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    microcode_sequencer_if.slave  bus
);

    logic             stall;
    logic             advance;
    mode_e            mode;
    mode_e            mode_next;

    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_d;
    logic [IR_W-1:0]  ir_q;
    logic [IR_W-1:0]  ir_d;
    logic             cond_q;
    logic             cond_d;
    logic             uerr_q;
    logic             uerr_d;
    logic [IR_W-1:0]  ir_field;
    logic             unused_ibus;

    assign stall   = !bus.nhalt || !bus.nwaiting;
    assign advance = !stall && bus.uend;

    microcode_sequencer_modefsm u_modefsm (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .irq_pend  (bus.irq_pend),
        .irq_en    (bus.irq_en),
        .mode      (mode),
        .mode_next (mode_next)
    );

    always_comb begin
        upc_d  = upc_q;
        ir_d   = ir_q;
        cond_d = cond_q;
        uerr_d = uerr_q;
        if (!stall) begin
            if (bus.uend) begin
                upc_d = '0;
            end else begin
                upc_d = upc_q + UPC_W'(1);
                if (upc_q == '1) begin
                    uerr_d = 1'b1;
                end
            end

            if (bus.ir_ld) begin
                ir_d = bus.ibus[IBUS_W-1 -: IR_W];
            end else if (mode == ModeReset) begin
                ir_d = '0;
            end

            // cond is captured entering EXEC and held through any IRQ sequence.
            if (advance) begin
                if (mode_next == ModeFetch) begin
                    cond_d = 1'b0;
                end else if (mode == ModeFetch) begin
                    cond_d = bus.cond_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q  <= '0;
            ir_q   <= '0;
            cond_q <= 1'b0;
            uerr_q <= 1'b0;
        end else begin
            upc_q  <= upc_d;
            ir_q   <= ir_d;
            cond_q <= cond_d;
            uerr_q <= uerr_d;
        end
    end

    // The reset vector never depends on a stale opcode.
    assign ir_field = (mode == ModeReset) ? '0 : ir_q;

    assign bus.uaddr = pack_uaddr(mode, ir_field, cond_q, upc_q);
    assign bus.mode  = mode;
    assign bus.uerr  = uerr_q;

    assign unused_ibus = ^bus.ibus[IBUS_W-IR_W-1:0];

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: expected uaddr/mode/uerr are queued with each
// stimulus step and compared after the following clock edge.
module tb_microcode_sequencer;
    import microcode_sequencer_pkg::*;

    typedef struct packed {
        logic [18:0] ua;
        logic [1:0]  md;
        logic        ue;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    microcode_sequencer_if bus ();

    microcode_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input logic [1:0] m, input logic [8:0] ir,
                                       input logic c, input logic [6:0] upc);
        return {m, ir, c, upc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Queue the expectation, clock once, then pop and compare.
    task automatic step(input string tag, input logic [18:0] ua, input logic ue);
        exp_t e;
        e.ua = ua;
        e.md = ua[18:17];
        e.ue = ue;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".uaddr"}, 32'(bus.uaddr), 32'(e.ua));
        chk({tag, ".mode"},  32'(bus.mode),  32'(e.md));
        chk({tag, ".uerr"},  32'(bus.uerr),  32'(e.ue));
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        bus.nhalt    = 1'b1;
        bus.nwaiting = 1'b1;
        bus.ibus     = 16'h0000;
        bus.ir_ld    = 1'b0;
        bus.uend     = 1'b0;
        bus.cond_in  = 1'b0;
        bus.irq_pend = 1'b0;
        bus.irq_en   = 1'b0;

        #2;
        chk("rst_uaddr", 32'(bus.uaddr), 32'h0);
        chk("rst_mode",  32'(bus.mode),  32'h0);
        chk("rst_uerr",  32'(bus.uerr),  32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_uaddr", 32'(bus.uaddr), 32'h0);
        reset = 1'b0;
        chk("rel_uaddr", 32'(bus.uaddr), 32'h0);

        // Reset vector counting, then uend on the third cycle.
        step("rvec1", mk(2'b00, 9'h000, 1'b0, 7'h01), 1'b0);
        step("rvec2", mk(2'b00, 9'h000, 1'b0, 7'h02), 1'b0);
        bus.uend = 1'b1;
        step("to_fetch", mk(2'b01, 9'h000, 1'b0, 7'h00), 1'b0);

        // Fetch with opcode load and condition capture.
        bus.ir_ld   = 1'b1;
        bus.ibus    = 16'hA380;
        bus.cond_in = 1'b1;
        step("to_exec", mk(2'b10, 9'h147, 1'b1, 7'h00), 1'b0);
        bus.ir_ld   = 1'b0;
        bus.uend    = 1'b0;
        bus.cond_in = 1'b0;
        bus.ibus    = 16'h0000;
        step("exec1", mk(2'b10, 9'h147, 1'b1, 7'h01), 1'b0);
        step("exec2", mk(2'b10, 9'h147, 1'b1, 7'h02), 1'b0);

        // EXEC end with an enabled pending interrupt.
        bus.uend     = 1'b1;
        bus.irq_pend = 1'b1;
        bus.irq_en   = 1'b1;
        step("to_irq", mk(2'b11, 9'h147, 1'b1, 7'h00), 1'b0);
        bus.irq_pend = 1'b0;
        bus.irq_en   = 1'b0;
        step("irq_to_fetch", mk(2'b01, 9'h147, 1'b0, 7'h00), 1'b0);
        step("fetch_c0", mk(2'b10, 9'h147, 1'b0, 7'h00), 1'b0);

        // Interrupt pending but disabled.
        bus.irq_pend = 1'b1;
        step("irq_dis", mk(2'b01, 9'h147, 1'b0, 7'h00), 1'b0);
        bus.irq_pend = 1'b0;
        bus.ir_ld    = 1'b1;
        bus.ibus     = 16'h1234;
        bus.cond_in  = 1'b1;
        step("to_exec2", mk(2'b10, 9'h024, 1'b1, 7'h00), 1'b0);

        // Interrupt pulsed mid-instruction only.
        bus.ir_ld    = 1'b0;
        bus.cond_in  = 1'b0;
        bus.uend     = 1'b0;
        bus.irq_pend = 1'b1;
        bus.irq_en   = 1'b1;
        step("mid_irq", mk(2'b10, 9'h024, 1'b1, 7'h01), 1'b0);
        bus.irq_pend = 1'b0;
        bus.uend     = 1'b1;
        step("mid_irq_end", mk(2'b01, 9'h024, 1'b0, 7'h00), 1'b0);
        bus.irq_en   = 1'b0;

        // Wait-state stall during EXEC with uend and ir_ld held high.
        step("to_exec3", mk(2'b10, 9'h024, 1'b0, 7'h00), 1'b0);
        bus.uend = 1'b0;
        step("exec3_1", mk(2'b10, 9'h024, 1'b0, 7'h01), 1'b0);
        bus.nwaiting = 1'b0;
        bus.uend     = 1'b1;
        bus.ir_ld    = 1'b1;
        bus.ibus     = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step("wait_frozen", mk(2'b10, 9'h024, 1'b0, 7'h01), 1'b0);
        end
        bus.nwaiting = 1'b1;
        bus.ir_ld    = 1'b0;
        step("wait_release", mk(2'b01, 9'h024, 1'b0, 7'h00), 1'b0);

        // Front-panel halt also freezes the mode transition.
        bus.nhalt = 1'b0;
        step("halt_frozen", mk(2'b01, 9'h024, 1'b0, 7'h00), 1'b0);
        bus.nhalt = 1'b1;
        step("halt_release", mk(2'b10, 9'h024, 1'b0, 7'h00), 1'b0);

        // 128 steps without uend: wrap and sticky error.
        bus.uend = 1'b0;
        for (int i = 1; i < 128; i++) begin
            step("ovf_count", mk(2'b10, 9'h024, 1'b0, 7'(i)), 1'b0);
        end
        step("ovf_wrap", mk(2'b10, 9'h024, 1'b0, 7'h00), 1'b1);
        bus.uend = 1'b1;
        step("uerr_sticky1", mk(2'b01, 9'h024, 1'b0, 7'h00), 1'b1);
        step("uerr_sticky2", mk(2'b10, 9'h024, 1'b0, 7'h00), 1'b1);
        bus.uend = 1'b0;
        step("uerr_sticky3", mk(2'b10, 9'h024, 1'b0, 7'h01), 1'b1);

        // Asynchronous reset between clock edges, mid-EXEC.
        #3;
        reset = 1'b1;
        #1;
        chk("async_uaddr", 32'(bus.uaddr), 32'h0);
        chk("async_mode",  32'(bus.mode),  32'h0);
        chk("async_uerr",  32'(bus.uerr),  32'h0);
        @(posedge clk);
        #1;
        chk("async_hold", 32'(bus.uaddr), 32'h0);
        reset = 1'b0;
        step("rvec_again", mk(2'b00, 9'h000, 1'b0, 7'h01), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
